// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/writeback/branch handshake bundle between the pipeline datapath and the hazard controller.
// The master side drives the instruction, writeback and branch-resolution inputs; the slave side drives the stall and flush controls.
interface pipe_hazard_ctrl_if;
  logic [31:0] if_instr;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic        br_resolve;
  logic        br_taken;
  logic        pc_write;
  logic        if_id_write;
  logic        id_bubble;
  logic        if_flush;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic [7:0]  flush_cnt;
  logic        proto_err;

  modport master (
    output if_instr, wb_valid, wb_reg, br_resolve, br_taken,
    input  pc_write, if_id_write, id_bubble, if_flush, state, stall_cnt, flush_cnt, proto_err
  );

  modport slave (
    input  if_instr, wb_valid, wb_reg, br_resolve, br_taken,
    output pc_write, if_id_write, id_bubble, if_flush, state, stall_cnt, flush_cnt, proto_err
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard-based load-use/branch/jump hazard controller for a single-issue pipeline.
// Control outputs are combinational from state, if_instr and scoreboard; state, scoreboard and counters update on the clock edge.
module pipe_hazard_ctrl (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    BR_WAIT = 2'b01,
    FLUSH   = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] sb_q, sb_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [7:0]  flush_cnt_q, flush_cnt_d;
  logic        proto_err_q, proto_err_d;

  // Only $t0-$t5 (8-13) and $s0-$s5 (16-21) are tracked; anything else yields an empty mask.
  function automatic logic [11:0] reg_mask(input logic [4:0] r);
    logic [11:0] m;
    m = '0;
    if (r >= 5'd8 && r <= 5'd13) begin
      m = 12'd1 << (r - 5'd8);
    end else if (r >= 5'd16 && r <= 5'd21) begin
      m = 12'd1 << (r - 5'd10);
    end
    return m;
  endfunction

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic        is_nop, is_rtype, is_ld_imm, is_st_br, is_bne, is_jump;
  logic        use_rs, use_rt;
  logic [11:0] src_mask, dst_mask, clr_mask;
  logic        hazard, issue;

  assign opcode    = bus.if_instr[31:26];
  assign rs        = bus.if_instr[25:21];
  assign rt        = bus.if_instr[20:16];
  assign rd        = bus.if_instr[15:11];

  assign is_nop    = (bus.if_instr == 32'd0);
  assign is_rtype  = !is_nop && (opcode == 6'b000000);
  assign is_ld_imm = (opcode == 6'b100011) || (opcode == 6'b001000);
  assign is_bne    = (opcode == 6'b000101);
  assign is_st_br  = (opcode == 6'b101011) || is_bne;
  assign is_jump   = (opcode != 6'b000000) && !is_ld_imm && !is_st_br;

  assign use_rs    = is_rtype || is_ld_imm || is_st_br;
  assign use_rt    = is_rtype || is_st_br;

  assign src_mask  = (use_rs ? reg_mask(rs) : 12'd0) | (use_rt ? reg_mask(rt) : 12'd0);
  assign dst_mask  = is_rtype ? reg_mask(rd) : (is_ld_imm ? reg_mask(rt) : 12'd0);
  assign clr_mask  = bus.wb_valid ? reg_mask(bus.wb_reg) : 12'd0;

  assign hazard    = (state_q == RUN) && |(src_mask & sb_q);
  assign issue     = (state_q == RUN) && !hazard;

  always_comb begin
    bus.pc_write    = 1'b1;
    bus.if_id_write = 1'b1;
    bus.id_bubble   = 1'b0;
    bus.if_flush    = 1'b0;
    state_d         = state_q;
    case (state_q)
      RUN: begin
        if (hazard) begin
          bus.pc_write    = 1'b0;
          bus.if_id_write = 1'b0;
          bus.id_bubble   = 1'b1;
        end else if (is_bne) begin
          state_d = BR_WAIT;
        end else if (is_jump) begin
          state_d = FLUSH;
        end
      end
      BR_WAIT: begin
        bus.pc_write    = bus.br_resolve;
        bus.if_id_write = 1'b0;
        bus.id_bubble   = 1'b1;
        bus.if_flush    = bus.br_resolve && bus.br_taken;
        if (bus.br_resolve) state_d = RUN;
      end
      FLUSH: begin
        bus.if_id_write = 1'b0;
        bus.id_bubble   = 1'b1;
        bus.if_flush    = 1'b1;
        state_d         = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Set is applied after clear so an issuing writer wins a same-edge retire of the same register.
  always_comb begin
    sb_d        = (sb_q & ~clr_mask) | (issue ? dst_mask : 12'd0);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    proto_err_d = proto_err_q;
    if (hazard && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    if (bus.if_flush && flush_cnt_q != 8'hFF) flush_cnt_d = flush_cnt_q + 8'd1;
    if (bus.br_resolve && state_q != BR_WAIT) proto_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      sb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
  assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a register-file-level reference model.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus ();
  pipe_hazard_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference model: pending flag per architectural register, mode 0=run 1=branch wait 2=flush.
  bit pend[32];
  int m_state;
  int m_stall;
  int m_flush;
  bit m_perr;

  logic [4:0] pool[10] = '{5'd0, 5'd7, 5'd8, 5'd9, 5'd13, 5'd14, 5'd16, 5'd21, 5'd22, 5'd31};

  localparam logic [31:0] LW_T0   = 32'h8E080000;
  localparam logic [31:0] ADD_T1  = 32'h010A4820;
  localparam logic [31:0] ADDI_T3 = 32'h212B0000;
  localparam logic [31:0] BNE     = 32'h15090004;
  localparam logic [31:0] JMP     = 32'h08000010;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit trk(input logic [4:0] r);
    return (r >= 5'd8 && r <= 5'd13) || (r >= 5'd16 && r <= 5'd21);
  endfunction

  // 0 nop, 1 R-type, 2 lw/addi, 3 sw, 4 bne, 5 jump
  function automatic int kind(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    if (ins == 32'd0) return 0;
    if (op == 6'h00) return 1;
    if (op == 6'h23 || op == 6'h08) return 2;
    if (op == 6'h2b) return 3;
    if (op == 6'h05) return 4;
    return 5;
  endfunction

  function automatic bit m_hazard(input logic [31:0] ins);
    int k;
    logic [4:0] rs, rt;
    k  = kind(ins);
    rs = ins[25:21];
    rt = ins[20:16];
    if (m_state != 0) return 0;
    if ((k inside {1, 2, 3, 4}) && trk(rs) && pend[rs]) return 1;
    if ((k inside {1, 3, 4}) && trk(rt) && pend[rt]) return 1;
    return 0;
  endfunction

  task automatic m_reset();
    foreach (pend[i]) pend[i] = 1'b0;
    m_state = 0;
    m_stall = 0;
    m_flush = 0;
    m_perr  = 1'b0;
  endtask

  task automatic m_expect(output bit pcw, output bit ifw, output bit bub, output bit fl);
    pcw = 1; ifw = 1; bub = 0; fl = 0;
    if (m_state == 0) begin
      if (m_hazard(bus.if_instr)) begin
        pcw = 0; ifw = 0; bub = 1;
      end
    end else if (m_state == 1) begin
      pcw = bus.br_resolve; ifw = 0; bub = 1; fl = bus.br_resolve && bus.br_taken;
    end else begin
      ifw = 0; bub = 1; fl = 1;
    end
  endtask

  task automatic m_advance();
    bit pcw, ifw, bub, fl, hz;
    int k, nxt;
    logic [4:0] dst;
    bit has_dst;
    if (!rst) begin
      m_reset();
      return;
    end
    m_expect(pcw, ifw, bub, fl);
    hz = m_hazard(bus.if_instr);
    k  = kind(bus.if_instr);
    if (hz && m_stall < 65535) m_stall++;
    if (fl && m_flush < 255) m_flush++;
    if (bus.br_resolve && m_state != 1) m_perr = 1'b1;
    if (bus.wb_valid && trk(bus.wb_reg)) pend[bus.wb_reg] = 1'b0;
    nxt = m_state;
    if (m_state == 0 && !hz) begin
      has_dst = (k == 1) || (k == 2);
      dst = (k == 1) ? bus.if_instr[15:11] : bus.if_instr[20:16];
      if (has_dst && trk(dst)) pend[dst] = 1'b1;
      if (k == 4) nxt = 1;
      else if (k == 5) nxt = 2;
    end else if (m_state == 1) begin
      if (bus.br_resolve) nxt = 0;
    end else if (m_state == 2) begin
      nxt = 0;
    end
    m_state = nxt;
  endtask

  // One clock: compare every output against the model mid-cycle, then advance the model on the edge.
  task automatic cycle();
    bit pcw, ifw, bub, fl;
    @(negedge clk);
    m_expect(pcw, ifw, bub, fl);
    check("pc_write",    32'(bus.pc_write),    32'(pcw));
    check("if_id_write", 32'(bus.if_id_write), 32'(ifw));
    check("id_bubble",   32'(bus.id_bubble),   32'(bub));
    check("if_flush",    32'(bus.if_flush),    32'(fl));
    check("state",       32'(bus.state),       32'(m_state));
    check("stall_cnt",   32'(bus.stall_cnt),   32'(m_stall));
    check("flush_cnt",   32'(bus.flush_cnt),   32'(m_flush));
    check("proto_err",   32'(bus.proto_err),   32'(m_perr));
    @(posedge clk);
    m_advance();
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic wbv, input logic [4:0] wbr,
                       input logic brr, input logic brt);
    bus.if_instr   = ins;
    bus.wb_valid   = wbv;
    bus.wb_reg     = wbr;
    bus.br_resolve = brr;
    bus.br_taken   = brt;
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, c;
    a = pool[$urandom_range(0, 9)];
    b = pool[$urandom_range(0, 9)];
    c = pool[$urandom_range(0, 9)];
    case ($urandom_range(0, 9))
      0:       return 32'd0;
      1, 2, 3: return {6'h00, a, b, c, 5'd0, 6'h20};
      4:       return {6'h23, a, b, 16'($urandom)};
      5:       return {6'h08, a, b, 16'($urandom)};
      6:       return {6'h2b, a, b, 16'($urandom)};
      7:       return {6'h05, a, b, 16'($urandom)};
      8:       return {6'h02, 26'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    m_reset();
    bus.if_instr = '0; bus.wb_valid = 1'b0; bus.wb_reg = '0;
    bus.br_resolve = 1'b0; bus.br_taken = 1'b0;

    // Held in reset: controls show free-running issue, all state cleared.
    @(posedge clk); @(posedge clk); #1;
    drive(JMP, 1'b0, 5'd0, 1'b1, 1'b1);
    check("rst_pc_write", 32'(bus.pc_write), 32'd1);
    check("rst_id_bubble", 32'(bus.id_bubble), 32'd0);
    check("rst_state", 32'(bus.state), 32'd0);
    cycle();
    rst = 1'b1;

    // Load-use stall then release by writeback of $t0.
    drive(LW_T0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("lu_lw_pc_write", 32'(bus.pc_write), 32'd1);
    cycle();
    drive(ADD_T1, 1'b0, 5'd0, 1'b0, 1'b0);
    check("lu_bubble", 32'(bus.id_bubble), 32'd1);
    check("lu_pc_write", 32'(bus.pc_write), 32'd0);
    cycle();
    check("lu_stall1", 32'(bus.stall_cnt), 32'd1);
    cycle();
    check("lu_stall2", 32'(bus.stall_cnt), 32'd2);
    drive(ADD_T1, 1'b1, 5'd8, 1'b0, 1'b0);
    check("lu_wb_still_bubble", 32'(bus.id_bubble), 32'd1);
    cycle();
    check("lu_stall3", 32'(bus.stall_cnt), 32'd3);

    // Add issues while $t1 retires on the same edge: pending $t1 must survive.
    drive(ADD_T1, 1'b1, 5'd9, 1'b0, 1'b0);
    check("col_add_issue", 32'(bus.pc_write), 32'd1);
    cycle();
    drive(ADDI_T3, 1'b0, 5'd0, 1'b0, 1'b0);
    check("col_t1_pending", 32'(bus.id_bubble), 32'd1);
    cycle();
    drive(ADDI_T3, 1'b1, 5'd9, 1'b0, 1'b0);
    cycle();
    drive(ADDI_T3, 1'b0, 5'd0, 1'b0, 1'b0);
    check("col_addi_issue", 32'(bus.pc_write), 32'd1);
    cycle();
    drive(32'd0, 1'b1, 5'd11, 1'b0, 1'b0);
    cycle();

    // Branch taken after three wait cycles.
    drive(BNE, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle();
    check("br_state_wait", 32'(bus.state), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      check("br_wait_pc_write", 32'(bus.pc_write), 32'd0);
      cycle();
      check("br_wait_state", 32'(bus.state), 32'd1);
    end
    drive(32'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    check("br_taken_flush", 32'(bus.if_flush), 32'd1);
    check("br_taken_pc_write", 32'(bus.pc_write), 32'd1);
    cycle();
    check("br_back_to_run", 32'(bus.state), 32'd0);
    check("br_flush_cnt", 32'(bus.flush_cnt), 32'd1);

    // Jump: exactly one flush cycle.
    drive(JMP, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle();
    check("jmp_state_flush", 32'(bus.state), 32'd2);
    check("jmp_if_flush", 32'(bus.if_flush), 32'd1);
    drive(32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle();
    check("jmp_back_to_run", 32'(bus.state), 32'd0);
    check("jmp_flush_cnt", 32'(bus.flush_cnt), 32'd2);

    // $zero is untracked: writing then reading it never stalls.
    drive(32'h20000005, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle();
    drive(32'h00005020, 1'b1, 5'd0, 1'b0, 1'b0);
    check("zero_no_stall", 32'(bus.pc_write), 32'd1);
    cycle();

    // br_resolve outside a branch wait is a sticky protocol error.
    drive(32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    cycle();
    check("perr_set", 32'(bus.proto_err), 32'd1);

    // Reset asserted in the middle of a branch wait wipes everything.
    drive(BNE, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle();
    check("rstw_in_wait", 32'(bus.state), 32'd1);
    rst = 1'b0;
    m_reset();
    drive(32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("rstw_state", 32'(bus.state), 32'd0);
    check("rstw_stall", 32'(bus.stall_cnt), 32'd0);
    check("rstw_flush", 32'(bus.flush_cnt), 32'd0);
    check("rstw_perr", 32'(bus.proto_err), 32'd0);
    cycle();
    rst = 1'b1;
    drive(ADD_T1, 1'b0, 5'd0, 1'b0, 1'b0);
    check("rstw_empty_sb", 32'(bus.pc_write), 32'd1);
    cycle();

    // Back-to-back jumps drive flush_cnt into saturation.
    for (int i = 0; i < 260; i++) begin
      drive(JMP, 1'b0, 5'd0, 1'b0, 1'b0);
      cycle();
      cycle();
    end
    check("flush_sat", 32'(bus.flush_cnt), 32'd255);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 4000; i++) begin
      logic brr;
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        m_reset();
      end
      brr = (m_state == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
      drive(rand_instr(), ($urandom_range(0, 2) == 0), pool[$urandom_range(0, 9)],
            brr, 1'($urandom_range(0, 1)));
      cycle();
      rst = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
